// File: rtl/shared_mem_arbiter.sv
// Single-port data RAM shared by NUM_CORES round-robin requesters and a
// priority host port; reads return one cycle after grant with a one-cycle rvalid.
module shared_mem_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 12,
   parameter int CNT_W     = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [CNT_W-1:0]            active_cores,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_we,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_gnt,
   output logic [NUM_CORES-1:0]        core_rvalid,
   output logic [DATA_W-1:0]           rdata,
   input  logic                        host_req,
   input  logic                        host_we,
   input  logic [ADDR_W-1:0]           host_addr,
   input  logic [DATA_W-1:0]           host_wdata,
   output logic                        host_gnt,
   output logic                        host_rvalid
);

   localparam int IDX_W = $clog2(NUM_CORES);
   localparam int SUM_W = IDX_W + 1;

   logic [DATA_W-1:0]    mem [2**ADDR_W];

   logic [IDX_W-1:0]     last_reg;
   logic [NUM_CORES-1:0] core_rvalid_reg;
   logic                 host_rvalid_reg;
   logic [DATA_W-1:0]    rdata_reg;

   logic [CNT_W-1:0]     eff_active;
   logic [NUM_CORES-1:0] eligible;
   logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
   logic [DATA_W-1:0]    wdata_arr [NUM_CORES];

   logic                 found;
   logic [IDX_W-1:0]     gnt_idx;
   logic [SUM_W-1:0]     scan;
   logic                 grant_core;
   logic                 acc_en;
   logic                 acc_we;
   logic [ADDR_W-1:0]    acc_addr;
   logic [DATA_W-1:0]    acc_wdata;

   // Counts above NUM_CORES saturate so the eligibility mask stays in range.
   assign eff_active = (active_cores > CNT_W'(NUM_CORES)) ? CNT_W'(NUM_CORES) : active_cores;

   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign eligible[gi]  = core_req[gi] & (eff_active > CNT_W'(gi));
      assign addr_arr[gi]  = core_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = core_wdata[gi*DATA_W +: DATA_W];
      assign core_gnt[gi]  = grant_core & (gnt_idx == IDX_W'(gi));
   end

   // Scan last+1 .. last+NUM_CORES modulo NUM_CORES; first eligible core wins.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      for (int k = 1; k <= NUM_CORES; k++) begin
         scan = {1'b0, last_reg} + SUM_W'(k);
         if (scan >= SUM_W'(NUM_CORES))
            scan = scan - SUM_W'(NUM_CORES);
         if (!found && eligible[scan[IDX_W-1:0]]) begin
            found   = 1'b1;
            gnt_idx = scan[IDX_W-1:0];
         end
      end
   end

   assign host_gnt   = rst_n & host_req;
   assign grant_core = rst_n & ~host_req & found;
   assign acc_en     = host_gnt | grant_core;
   assign acc_we     = host_req ? host_we    : core_we[gnt_idx];
   assign acc_addr   = host_req ? host_addr  : addr_arr[gnt_idx];
   assign acc_wdata  = host_req ? host_wdata : wdata_arr[gnt_idx];

   always_ff @(posedge clk) begin
      if (acc_en && acc_we)
         mem[acc_addr] <= acc_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_reg        <= IDX_W'(NUM_CORES - 1);
         core_rvalid_reg <= '0;
         host_rvalid_reg <= 1'b0;
         rdata_reg       <= '0;
      end else begin
         if (grant_core)
            last_reg <= gnt_idx;
         core_rvalid_reg <= (grant_core && !acc_we) ? core_gnt : '0;
         host_rvalid_reg <= host_gnt & ~host_we;
         if (acc_en && !acc_we)
            rdata_reg <= mem[acc_addr];
      end
   end

   assign core_rvalid = core_rvalid_reg;
   assign host_rvalid = host_rvalid_reg;
   assign rdata       = rdata_reg;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed vector table for shared_mem_arbiter plus a reset-during-read sequence.
module tb_shared_mem_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 12;
   localparam int CW = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [CW-1:0]   active_cores;
   logic [N-1:0]    core_req, core_we;
   logic [N*AW-1:0] core_addr;
   logic [N*DW-1:0] core_wdata;
   logic [N-1:0]    core_gnt, core_rvalid;
   logic [DW-1:0]   rdata;
   logic            host_req, host_we;
   logic [AW-1:0]   host_addr;
   logic [DW-1:0]   host_wdata;
   logic            host_gnt, host_rvalid;

   shared_mem_arbiter #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .active_cores(active_cores),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .rdata(rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid)
   );

   always #5 clk = ~clk;

   // Core i uses address addr+16*i and write data wdata+i.
   typedef struct {
      logic          rst;
      logic [CW-1:0] act;
      logic [N-1:0]  req, we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          hreq, hwe;
      logic [AW-1:0] haddr;
      logic [DW-1:0] hwdata;
      logic [N-1:0]  egnt;
      logic          ehgnt;
      logic [N-1:0]  erv;
      logic          ehrv;
      logic          chk;
      logic [DW-1:0] erd;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   cur    = 0;

   task automatic add(input logic rst, input logic [CW-1:0] act, input logic [N-1:0] req,
                      input logic [N-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic hreq, input logic hwe, input logic [AW-1:0] haddr,
                      input logic [DW-1:0] hwdata, input logic [N-1:0] egnt, input logic ehgnt,
                      input logic [N-1:0] erv, input logic ehrv, input logic chk,
                      input logic [DW-1:0] erd);
      vec_t v;
      v.rst = rst; v.act = act; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
      v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwdata = hwdata;
      v.egnt = egnt; v.ehgnt = ehgnt; v.erv = erv; v.ehrv = ehrv; v.chk = chk; v.erd = erd;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, cur, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n        = v.rst;
      active_cores = v.act;
      core_req     = v.req;
      core_we      = v.we;
      for (int i = 0; i < N; i++) begin
         core_addr[i*AW +: AW]  = v.addr + AW'(16 * i);
         core_wdata[i*DW +: DW] = v.wdata + DW'(i);
      end
      host_req   = v.hreq;
      host_we    = v.hwe;
      host_addr  = v.haddr;
      host_wdata = v.hwdata;
   endtask

   initial begin
      vec_t v;
      // reset with writes pending: nothing granted, nothing written
      add(0, 4, 4'b1111, 4'b1111, 12'h010, 32'h11111111, 1, 1, 12'h010, 32'h22222222, 4'b0000, 0, 4'b0000, 0, 1, 32'h0);
      add(0, 4, 4'b0000, 4'b0000, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0000, 0, 4'b0000, 0, 1, 32'h0);
      add(1, 4, 4'b0000, 4'b0000, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0000, 0, 4'b0000, 0, 1, 32'h0);
      // core 2 writes DEADBEEF @0x010 then reads it back
      add(1, 4, 4'b0100, 4'b0100, 12'hFF0, 32'hDEADBEED, 0, 0, 12'h000, 32'h0,        4'b0100, 0, 4'b0000, 0, 1, 32'h0);
      add(1, 4, 4'b0100, 4'b0000, 12'hFF0, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0100, 0, 4'b0100, 0, 1, 32'hDEADBEEF);
      // reset again with writes to 0x010 attempted; contents must survive
      add(0, 4, 4'b1111, 4'b1111, 12'h010, 32'h33333333, 1, 1, 12'h010, 32'hBADBADBA, 4'b0000, 0, 4'b0000, 0, 1, 32'h0);
      add(1, 4, 4'b0000, 4'b0000, 12'h000, 32'h0,        1, 0, 12'h010, 32'h0,        4'b0000, 1, 4'b0000, 1, 1, 32'hDEADBEEF);
      // round robin writes then reads, starting at core 0
      for (int i = 0; i < N; i++)
         add(1, 4, 4'b1111, 4'b1111, 12'h100, 32'hA0000000, 0, 0, 12'h000, 32'h0, 4'(1 << i), 0, 4'b0000, 0, 1, 32'hDEADBEEF);
      for (int i = 0; i < N; i++)
         add(1, 4, 4'b1111, 4'b0000, 12'h100, 32'h0, 0, 0, 12'h000, 32'h0, 4'(1 << i), 0, 4'(1 << i), 0, 1, 32'hA0000000 + 32'(i));
      // host priority; core pointer resumes at core 0
      add(1, 4, 4'b1111, 4'b0000, 12'h100, 32'h0,        1, 1, 12'h7FF, 32'h00000055, 4'b0000, 1, 4'b0000, 0, 1, 32'hA0000003);
      add(1, 4, 4'b1111, 4'b0000, 12'h100, 32'h0,        1, 0, 12'h7FF, 32'h0,        4'b0000, 1, 4'b0000, 1, 1, 32'h00000055);
      add(1, 4, 4'b1111, 4'b0000, 12'h100, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0001, 0, 4'b0001, 0, 1, 32'hA0000000);
      // masking to two cores
      add(1, 2, 4'b1111, 4'b0000, 12'h100, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0010, 0, 4'b0010, 0, 1, 32'hA0000001);
      add(1, 2, 4'b1111, 4'b0000, 12'h100, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0001, 0, 4'b0001, 0, 1, 32'hA0000000);
      add(1, 2, 4'b1111, 4'b0000, 12'h100, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0010, 0, 4'b0010, 0, 1, 32'hA0000001);
      add(1, 2, 4'b1111, 4'b0000, 12'h100, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0001, 0, 4'b0001, 0, 1, 32'hA0000000);
      // zero active cores, then an over-range count
      add(1, 0, 4'b1111, 4'b0000, 12'h100, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0000, 0, 4'b0000, 0, 1, 32'hA0000000);
      add(1, 7, 4'b1111, 4'b0000, 12'h100, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0010, 0, 4'b0010, 0, 1, 32'hA0000001);
      // sparse requests wrap past idle cores
      add(1, 4, 4'b1001, 4'b0000, 12'h100, 32'h0,        0, 0, 12'h000, 32'h0,        4'b1000, 0, 4'b1000, 0, 1, 32'hA0000003);
      add(1, 4, 4'b1001, 4'b0000, 12'h100, 32'h0,        0, 0, 12'h000, 32'h0,        4'b0001, 0, 4'b0001, 0, 1, 32'hA0000000);

      v = vecs[1];
      drive(v);
      @(posedge clk); #1;
      foreach (vecs[k]) begin
         cur = k;
         drive(vecs[k]);
         #4;
         check("core_gnt", DW'(core_gnt), DW'(vecs[k].egnt));
         check("host_gnt", DW'(host_gnt), DW'(vecs[k].ehgnt));
         @(posedge clk); #1;
         check("core_rvalid", DW'(core_rvalid), DW'(vecs[k].erv));
         check("host_rvalid", DW'(host_rvalid), DW'(vecs[k].ehrv));
         if (vecs[k].chk)
            check("rdata", rdata, vecs[k].erd);
         $display("step %0d: req=%b gnt=%b hgnt=%b rvalid=%b hrvalid=%b rdata=%h",
                  k, vecs[k].req, core_gnt, host_gnt, core_rvalid, host_rvalid, rdata);
      end

      // reset lands on the edge that would complete a core 1 read
      cur = 100;
      v = vecs[2];
      v.req = 4'b0010;
      v.addr = 12'h100;
      drive(v);
      #4;
      check("midrst_gnt", DW'(core_gnt), DW'(4'b0010));
      #1 rst_n = 1'b0;
      #1;
      check("midrst_gnt_in_reset", DW'(core_gnt), DW'(4'b0000));
      @(posedge clk); #1;
      rst_n = 1'b1;
      core_req = 4'b1001;
      check("midrst_rvalid", DW'(core_rvalid), DW'(4'b0000));
      check("midrst_rdata", rdata, 32'h0);
      #3;
      check("post_rst_gnt", DW'(core_gnt), DW'(4'b0001));
      @(posedge clk); #1;
      check("post_rst_rvalid", DW'(core_rvalid), DW'(4'b0001));
      check("post_rst_rdata", rdata, 32'hA0000000);
      $display("reset-mid-read: rvalid=%b rdata=%h", core_rvalid, rdata);

      core_req = '0;
      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Parametrised shared data-memory block for the multi-core processor: a single-port synchronous data RAM behind an N-way round-robin arbiter plus a priority host (file-load) port. It replaces the fixed four-port data memory. Cores issue request/grant transactions, so any core count up to `NUM_CORES` shares one physical memory port without write collisions. A runtime `active_cores` input masks unused cores.

## Interface
- `NUM_CORES`, 4, number of core request channels (≥2)
- `DATA_W`, 32, data word width
- `ADDR_W`, 12, word address width; memory depth is 2^ADDR_W words
- `CNT_W`, 3, width of `active_cores`; must hold `NUM_CORES`

- `clk` in 1: single clock; all state updates on its rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `active_cores` in CNT_W: number of enabled cores; requests from core index ≥ `active_cores` are ignored
- `core_req` in NUM_CORES: per-core access request, level
- `core_we` in NUM_CORES: per-core write (1) / read (0)
- `core_addr` in NUM_CORES*ADDR_W: packed addresses; core i occupies bits [i*ADDR_W +: ADDR_W]
- `core_wdata` in NUM_CORES*DATA_W: packed write data, same packing
- `core_gnt` out NUM_CORES: one-hot (or zero) grant for the current cycle
- `core_rvalid` out NUM_CORES: one-hot read-data-valid
- `rdata` out DATA_W: read data shared by all cores and the host; qualified by `core_rvalid`/`host_rvalid`
- `host_req`, `host_we` in 1: host access request / write select
- `host_addr` in ADDR_W, `host_wdata` in DATA_W: host address / write data
- `host_gnt` out 1: host grant
- `host_rvalid` out 1: host read-data-valid

## Operation
- Every cycle, at most one requester is granted. Host has absolute priority: `host_req`=1 forces `host_gnt`=1 and all `core_gnt`=0.
- Otherwise, among eligible cores (`core_req[i]`=1 and i < `active_cores`), grant goes to the first one found scanning upward, with wrap-around, from `last+1`. `last` is the index of the most recently granted core.
- `last` updates only on a core grant. Host grants and idle cycles leave it unchanged.
- `active_cores` = 0 disables all cores. `active_cores` > `NUM_CORES` behaves as `NUM_CORES`.
- Grant is a combinational function of current requests and `last`. The granted access executes at the end of that cycle.
- A write stores the granted wdata at the granted address.
- A read captures mem[addr] into `rdata`. Next cycle it pulses the matching `core_rvalid[i]` or `host_rvalid` for exactly one cycle.
- Requester handshake: hold req/we/addr/wdata stable until gnt is seen high. Deassert or change the request in the cycle after the grant. A request still held after its grant is treated as a new access.
- No write-then-read hazard: a read granted the cycle after a write to the same address returns the new data.
- Memory contents are not reset. Reads of never-written words return X in simulation.
- `rdata` holds its last value when no read completes.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - `last` ← NUM_CORES-1, so core 0 wins first.
  - `core_rvalid`=0, `host_rvalid`=0, `rdata`=0.
- While `rst_n`=0: `core_gnt`=0 and `host_gnt`=0 combinationally. No memory write occurs.
- Reset mid-operation: a read granted in cycle t with reset at the end of t produces no rvalid in t+1. The requester must re-request.
- Grant latency: 0 cycles from a request when uncontended.
- Read latency: data and rvalid 1 cycle after grant. Write latency: committed at the grant edge.
- Throughput: 1 access per cycle, sustained.
- Starvation bound: a held eligible core request is granted within `active_cores` cycles, provided the host is idle.
- Simultaneous events:
  - Host and core requests in the same cycle: host wins and `last` is unchanged.
  - `active_cores` changing while a request is pending takes effect the same cycle.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles, release, no requests → all gnt/rvalid 0, `rdata`=0.
- Single core write/read: core 2 writes 0xDEADBEEF @0x010, then reads @0x010 → `core_gnt`=4'b0100 each cycle; `core_rvalid`=4'b0100 one cycle after the read grant with `rdata`=0xDEADBEEF.
- Round-robin fairness: after reset, all 4 cores hold read requests for 8 cycles → grant order 0,1,2,3,0,1,2,3; each `core_rvalid` lags its grant by 1.
- Host priority: host writes 0x00000055 @0x7FF while cores 0–3 request → `host_gnt`=1 and `core_gnt`=0 that cycle; the next core grant continues from the pre-host pointer.
- Core masking: `active_cores`=2, cores 0–3 all requesting → grants alternate 0,1,0,1; cores 2 and 3 are never granted.
- Reset mid-read: core 1 read granted, `rst_n`=0 at that edge → no `core_rvalid` next cycle; after release, the first grant goes to core 0 if requesting.
